// File: rtl/cycle_timer.sv
// cycle_timer: free-running, prescaled cycle counter with a shadowed terminal
// value, a registered wrap pulse and an epoch (wrap) counter. It provides
// slot/period timing to the rx and scheduling logic.
//
// Optional compare output is built only when TIMER_CMP_EN is defined.
// Without it, the cmp_value/cmp_hit ports and their logic do not exist.
module cycle_timer #(
  parameter int          TW         = 19,
  parameter int          PRE_W      = 8,
  parameter int          EPOCH_W    = 16,
  parameter int unsigned DEF_PERIOD = 499999
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               timer_rst,
  input  logic               timer_en,
  input  logic [PRE_W-1:0]   prescale,
  input  logic               period_wr,
  input  logic [TW-1:0]      period_wdata,
  output logic [TW-1:0]      timer,
  output logic [TW-1:0]      period_cur,
  output logic               wrap_pulse,
  output logic [EPOCH_W-1:0] epoch
`ifdef TIMER_CMP_EN
  ,
  input  logic [TW-1:0]      cmp_value,
  output logic               cmp_hit
`endif
);

  localparam logic [TW-1:0] DEF_P = TW'(DEF_PERIOD);

  logic [PRE_W-1:0] pre_cnt;
  logic [TW-1:0]    shadow;
  logic             pending;
  logic             tick;
  logic             at_term;
  logic             wrap_tick;
  logic [TW-1:0]    timer_nxt;

  // A prescale value lowered below the running pre_cnt counts as a tick, so
  // the prescaler never has to run all the way round its field width.
  assign tick      = timer_en && (pre_cnt >= prescale);
  assign at_term   = (timer == period_cur);
  assign wrap_tick = tick && at_term;
  assign timer_nxt = at_term ? '0 : timer + TW'(1);

  // Prescaler: counts enabled cycles, restarts after every tick.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || timer_rst) begin
      pre_cnt <= '0;
    end else if (timer_en) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Main count, epoch and the wrap pulse that lines up with timer == 0.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || timer_rst) begin
      timer      <= '0;
      epoch      <= '0;
      wrap_pulse <= 1'b0;
    end else if (!timer_en) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap_tick;
      if (tick) begin
        timer <= timer_nxt;
        if (at_term) begin
          epoch <= epoch + EPOCH_W'(1);
        end
      end
    end
  end

  // Period shadow: writes are parked in shadow and only take effect at a
  // wrap or soft restart. A write landing on that same cycle bypasses it.
  // When nothing is pending, shadow already equals period_cur.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      period_cur <= DEF_P;
      shadow     <= DEF_P;
      pending    <= 1'b0;
    end else begin
      if (period_wr) begin
        shadow <= period_wdata;
      end
      if (timer_rst || wrap_tick) begin
        period_cur <= period_wr ? period_wdata : shadow;
        pending    <= 1'b0;
      end else if (period_wr) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef TIMER_CMP_EN
  // Compare pulse: registered, fires when a tick lands timer on cmp_value.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || timer_rst) begin
      cmp_hit <= 1'b0;
    end else begin
      cmp_hit <= tick && (timer_nxt == cmp_value) && (cmp_value <= period_cur);
    end
  end
`endif

endmodule

// File: tb/tb_cycle_timer.sv
// Testbench for cycle_timer: directed scenarios followed by random stimulus.
// All outputs are checked every cycle against a behavioural model.
// The compare output is checked only when TIMER_CMP_EN is defined.
module tb_cycle_timer;

  localparam int TW         = 12;
  localparam int PRE_W      = 4;
  localparam int EPOCH_W    = 2;
  localparam int DEF_PERIOD = 1000;

  logic               clk_sys = 1'b0;
  logic               reset_n = 1'b0;
  logic               timer_rst = 1'b0;
  logic               timer_en = 1'b0;
  logic [PRE_W-1:0]   prescale = '0;
  logic               period_wr = 1'b0;
  logic [TW-1:0]      period_wdata = '0;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      period_cur;
  logic               wrap_pulse;
  logic [EPOCH_W-1:0] epoch;
`ifdef TIMER_CMP_EN
  logic [TW-1:0]      cmp_value = '0;
  logic               cmp_hit;
`endif

  cycle_timer #(
    .TW(TW), .PRE_W(PRE_W), .EPOCH_W(EPOCH_W), .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .timer_rst(timer_rst),
    .timer_en(timer_en),
    .prescale(prescale),
    .period_wr(period_wr),
    .period_wdata(period_wdata),
    .timer(timer),
    .period_cur(period_cur),
    .wrap_pulse(wrap_pulse),
    .epoch(epoch)
`ifdef TIMER_CMP_EN
    ,
    .cmp_value(cmp_value),
    .cmp_hit(cmp_hit)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, plain integers.
  int m_timer, m_pre, m_epoch, m_period, m_shadow;
  bit m_pending, m_wrap;
`ifdef TIMER_CMP_EN
  bit m_cmp;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock of the timer's rules, using the inputs present at the edge.
  task automatic model_step();
    int  emod;
    bit  tick;
    bit  wrapped;
    emod = 1 << EPOCH_W;
    if (!reset_n) begin
      m_timer = 0; m_pre = 0; m_epoch = 0; m_wrap = 0;
      m_period = DEF_PERIOD; m_shadow = DEF_PERIOD; m_pending = 0;
`ifdef TIMER_CMP_EN
      m_cmp = 0;
`endif
      return;
    end
    if (timer_rst) begin
      m_timer = 0; m_pre = 0; m_epoch = 0; m_wrap = 0;
      m_period = period_wr ? int'(period_wdata) : m_shadow;
      if (period_wr) m_shadow = int'(period_wdata);
      m_pending = 0;
`ifdef TIMER_CMP_EN
      m_cmp = 0;
`endif
      return;
    end
    m_wrap = 0;
`ifdef TIMER_CMP_EN
    m_cmp = 0;
`endif
    if (!timer_en) begin
      if (period_wr) begin
        m_shadow  = int'(period_wdata);
        m_pending = 1;
      end
      return;
    end
    tick    = (m_pre >= int'(prescale));
    m_pre   = tick ? 0 : m_pre + 1;
    wrapped = 0;
    if (tick) begin
      if (m_timer == m_period) begin
        wrapped = 1;
        m_timer = 0;
        m_epoch = (m_epoch + 1) % emod;
        m_wrap  = 1;
        if (period_wr)      m_period = int'(period_wdata);
        else if (m_pending) m_period = m_shadow;
        m_pending = 0;
      end else begin
        m_timer = m_timer + 1;
      end
`ifdef TIMER_CMP_EN
      m_cmp = (m_timer == int'(cmp_value));
`endif
    end
    if (period_wr) begin
      m_shadow = int'(period_wdata);
      if (!wrapped) m_pending = 1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk_sys);
    model_step();
    #1;
    check({tag, ".timer"},      32'(timer),      32'(m_timer));
    check({tag, ".period_cur"}, 32'(period_cur), 32'(m_period));
    check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_wrap));
    check({tag, ".epoch"},      32'(epoch),      32'(m_epoch));
`ifdef TIMER_CMP_EN
    check({tag, ".cmp_hit"},    32'(cmp_hit),    32'(m_cmp));
`endif
  endtask

  task automatic write_and_restart(input int value);
    period_wr = 1'b1; period_wdata = TW'(value); timer_rst = 1'b1;
    step("restart");
    period_wr = 1'b0; timer_rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    reset_n = 1'b0;
    step("reset");
    step("reset");
    check("reset.period_def", 32'(period_cur), 32'(DEF_PERIOD));
    check("reset.timer0", 32'(timer), 32'd0);
    reset_n = 1'b1;

    // Period 4, then soft restart, prescale 0.
    period_wr = 1'b1; period_wdata = TW'(4);
    step("wr4");
    period_wr = 1'b0;
    check("wr4.held", 32'(period_cur), 32'(DEF_PERIOD));
    timer_rst = 1'b1;
    step("trst");
    timer_rst = 1'b0; timer_en = 1'b1; prescale = '0;
    for (int i = 0; i < 12; i++) step("p4");
    check("p4.timer_seq", 32'(timer), 32'd2);
    check("p4.epoch_seq", 32'(epoch), 32'd2);

    // Prescale 2, period 3, with a hold in the middle.
    prescale = PRE_W'(2);
    write_and_restart(3);
    for (int i = 0; i < 17; i++) step("pre2");
    timer_en = 1'b0;
    for (int i = 0; i < 5; i++) step("hold");
    timer_en = 1'b1;
    for (int i = 0; i < 20; i++) step("resume");

    // Shadowed writes: the last one before the wrap wins.
    prescale = '0;
    write_and_restart(4);
    for (int i = 0; i < 8 && m_timer != 1; i++) step("seek1");
    period_wr = 1'b1; period_wdata = TW'(2);
    step("wr2");
    period_wr = 1'b0;
    for (int i = 0; i < 8 && m_timer != 3; i++) step("seek3");
    period_wr = 1'b1; period_wdata = TW'(6);
    step("wr6");
    period_wr = 1'b0;
    check("wr6.no_midchange", 32'(period_cur), 32'd4);
    for (int i = 0; i < 15; i++) step("p6");

    // Write coincident with the wrap tick bypasses the shadow.
    for (int i = 0; i < 10 && m_timer != m_period; i++) step("seek_term");
    period_wr = 1'b1; period_wdata = TW'(7);
    step("wr_wrap");
    period_wr = 1'b0;
    check("wr_wrap.period", 32'(period_cur), 32'd7);
    check("wr_wrap.timer", 32'(timer), 32'd0);
    for (int i = 0; i < 4; i++) step("p7");

    // Write coincident with soft restart.
    write_and_restart(5);
    check("wr_trst.period", 32'(period_cur), 32'd5);
    check("wr_trst.epoch", 32'(epoch), 32'd0);

    // Period 0: wrap every tick, epoch cycles modulo 4.
    write_and_restart(0);
    for (int i = 0; i < 6; i++) step("p0");
    check("p0.wrap_high", 32'(wrap_pulse), 32'd1);
    check("p0.epoch_mod", 32'(epoch), 32'd2);

    // Prescale lowered below the running prescaler count.
    write_and_restart(3);
    prescale = PRE_W'(7);
    for (int i = 0; i < 5; i++) step("pre7");
    prescale = PRE_W'(1);
    for (int i = 0; i < 6; i++) step("pre1");
    prescale = '0;

`ifdef TIMER_CMP_EN
    // Compare hits.
    cmp_value = TW'(5);
    write_and_restart(9);
    for (int i = 0; i < 25; i++) step("cmp5");
    cmp_value = TW'(12);
    for (int i = 0; i < 25; i++) step("cmp12");
    cmp_value = TW'(0);
    for (int i = 0; i < 12; i++) step("cmp0");
`endif

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      timer_rst = ($urandom_range(0, 63) == 0);
      timer_en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) prescale = PRE_W'($urandom_range(0, 3));
      period_wr    = ($urandom_range(0, 15) == 0);
      period_wdata = TW'($urandom_range(0, 9));
`ifdef TIMER_CMP_EN
      if ($urandom_range(0, 15) == 0) cmp_value = TW'($urandom_range(0, 11));
`endif
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
